axi_ctrl_regfile: RTL

- Parametrised AXI3 slave exposing NUM_REGS 32-bit control registers to the PS; next generation of the single-beat, write-only computer control port.
- Adds a read channel, INCR/FIXED bursts, byte strobes, per-register pulse-only mode, sticky per-register written flags and SLVERR reporting.
- Sits between the AXI GP port and the computer core.
- Core consumes `reg_q`, `reg_valid` and `reg_wr_pulse`.

---
 rtl/axi_ctrl_pkg.sv | 26 ++
 rtl/axi_ctrl_beat_addr.sv | 73 +++++++
 rtl/axi_ctrl_regfile.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ctrl_pkg.sv
// Shared AXI encodings, FSM state types and the request legality check
// used by both channels of the control register file.
package axi_ctrl_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  // Bursts that fail this check are still consumed but never touch a register.
  function automatic logic req_error(input logic [2:0] size,
                                     input logic [1:0] addr_lo,
                                     input logic [7:0] len,
                                     input logic [1:0] burst);
    return (size != SIZE_WORD) || (addr_lo != 2'b00) || (len > 8'd15) ||
           (burst == BURST_WRAP) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/axi_ctrl_beat_addr.sv
// Burst address walker: tracks the current beat address and count and decodes
// it into a register index, a range flag and a last-beat flag.
module axi_ctrl_beat_addr
  import axi_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned IDX_W     = 2,
  parameter logic        LOOKAHEAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [31:0]      load_addr,
  input  logic [7:0]       load_len,
  input  logic [1:0]       load_burst,
  input  logic             advance,
  output logic [IDX_W-1:0] idx,
  output logic             in_range,
  output logic             is_last
);

  logic [31:0] addr_q;
  logic [7:0]  cnt_q;
  logic [7:0]  len_q;
  logic        incr_q;

  logic [31:0] step_addr;
  logic [31:0] view_addr;
  logic [31:0] offset;
  logic [7:0]  view_cnt;
  logic [7:0]  view_len;

  // With LOOKAHEAD the decode already shows the beat being started this cycle,
  // so the read side can launch a beat in the same cycle as its handshake.
  always_comb begin
    step_addr = incr_q ? (addr_q + 32'd4) : addr_q;
    view_addr = addr_q;
    view_cnt  = cnt_q;
    view_len  = len_q;
    if (load) begin
      view_addr = load_addr;
      view_cnt  = '0;
      view_len  = load_len;
    end else if (LOOKAHEAD && advance) begin
      view_addr = step_addr;
      view_cnt  = cnt_q + 8'd1;
    end
    offset = view_addr - BASE_ADDR;
  end

  assign in_range = (offset < 32'(NUM_REGS * 4));
  assign idx      = offset[IDX_W+1:2];
  assign is_last  = (view_cnt == view_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      incr_q <= 1'b0;
    end else if (load) begin
      addr_q <= load_addr;
      cnt_q  <= '0;
      len_q  <= load_len;
      incr_q <= (load_burst == BURST_INCR);
    end else if (advance) begin
      addr_q <= step_addr;
      cnt_q  <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/axi_ctrl_regfile.sv
// AXI3 slave exposing NUM_REGS 32-bit control registers with bursts, strobes,
// pulse-only registers, sticky written flags and SLVERR reporting.
module axi_ctrl_regfile
  import axi_ctrl_pkg::*;
#(
  parameter logic [31:0]         BASE_ADDR  = 32'h4000_0000,
  parameter int unsigned         NUM_REGS   = 4,
  parameter int unsigned         ID_W       = 12,
  parameter logic [NUM_REGS-1:0] PULSE_MASK = 'b0010
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ID_W-1:0]          awid,
  input  logic [31:0]              awaddr,
  input  logic [7:0]               awlen,
  input  logic [2:0]               awsize,
  input  logic [1:0]               awburst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [ID_W-1:0]          wid,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [ID_W-1:0]          bid,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ID_W-1:0]          arid,
  input  logic [31:0]              araddr,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [ID_W-1:0]          rid,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      reg_valid,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;

  logic [31:0] regs [NUM_REGS];

  logic aw_hs, w_hs, ar_hs, r_hs;
  logic w_req_err, w_err, w_commit, w_beat_err;
  logic [IDX_W-1:0] w_idx;
  logic w_in_range, w_last_beat;

  logic r_req_err, r_launch, r_launch_err, r_last_beat, r_in_range;
  logic [IDX_W-1:0] r_idx;
  logic [31:0] r_launch_data;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  axi_ctrl_beat_addr #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W),
    .LOOKAHEAD (1'b0)
  ) u_wr_addr (
    .clk        (clk),
    .rst        (rst),
    .load       (aw_hs),
    .load_addr  (awaddr),
    .load_len   (awlen),
    .load_burst (awburst),
    .advance    (w_hs),
    .idx        (w_idx),
    .in_range   (w_in_range),
    .is_last    (w_last_beat)
  );

  axi_ctrl_beat_addr #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W),
    .LOOKAHEAD (1'b1)
  ) u_rd_addr (
    .clk        (clk),
    .rst        (rst),
    .load       (ar_hs),
    .load_addr  (araddr),
    .load_len   (arlen),
    .load_burst (arburst),
    .advance    (r_hs && !rlast),
    .idx        (r_idx),
    .in_range   (r_in_range),
    .is_last    (r_last_beat)
  );

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign w_commit   = w_hs && !w_req_err && (wid == bid) && w_in_range;
  assign w_beat_err = !w_commit || (wlast != w_last_beat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      bid       <= '0;
      bresp     <= RESP_OKAY;
      w_req_err <= 1'b0;
      w_err     <= 1'b0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        bid       <= awid;
        w_req_err <= req_error(awsize, awaddr[1:0], awlen, awburst);
        w_err     <= 1'b0;
      end
      if (w_hs) begin
        if (w_beat_err) w_err <= 1'b1;
        if (w_last_beat) bresp <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_valid    <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (w_commit) begin
        reg_valid[w_idx]    <= 1'b1;
        reg_wr_pulse[w_idx] <= 1'b1;
        if (!PULSE_MASK[w_idx]) begin
          for (int unsigned k = 0; k < 4; k++) begin
            if (wstrb[k]) regs[w_idx][8*k +: 8] <= wdata[8*k +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) reg_q[32*i +: 32] = regs[i];
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Data is sampled from the registers before this edge's write commit lands,
  // so a read launched alongside a write to the same register sees the old value.
  assign r_launch      = ar_hs || (r_hs && !rlast);
  assign r_launch_err  = (ar_hs ? req_error(arsize, araddr[1:0], arlen, arburst) : r_req_err) ||
                         !r_in_range;
  assign r_launch_data = (r_launch_err || PULSE_MASK[r_idx]) ? '0 : regs[r_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= R_IDLE;
      rid       <= '0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
      rlast     <= 1'b0;
      r_req_err <= 1'b0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        rid       <= arid;
        r_req_err <= req_error(arsize, araddr[1:0], arlen, arburst);
      end
      if (r_launch) begin
        rdata <= r_launch_data;
        rresp <= r_launch_err ? RESP_SLVERR : RESP_OKAY;
        rlast <= r_last_beat;
      end else if (r_hs) begin
        rlast <= 1'b0;
      end
    end
  end

endmodule
